// File: rtl/qspi_host_interface_pkg.sv
// qspi_host_interface_pkg
//   Shared definitions for the QSPI host and the device-side interface:
//   the controller state enumeration, the default SCK divider and
//   turnaround length, and a helper that picks one instruction nibble.
//   No ports (package).
package qspi_host_interface_pkg;

   localparam int unsigned DEFAULT_CLK_DIV    = 2;
   localparam int unsigned DEFAULT_TURNAROUND = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_INSN,
      ST_TURNAROUND,
      ST_DATA,
      ST_CS_HOLD,
      ST_CS_IDLE
   } qspi_state_t;

   // Nibble idx of a 16-bit instruction, idx 0 = most significant.
   function automatic logic [3:0] insn_nibble(input logic [15:0] word, input logic [1:0] idx);
      logic [3:0] nib;
      case (idx)
         2'd0:    nib = word[15:12];
         2'd1:    nib = word[11:8];
         2'd2:    nib = word[7:4];
         default: nib = word[3:0];
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/qspi_sck_divider.sv
// qspi_sck_divider
//   Generates the SCK level from clk. While run=1 the clock toggles every
//   CLK_DIV clk cycles, starting low. rise/fall are one-cycle strobes that
//   are high in the clk cycle whose closing edge moves SCK up/down, so the
//   controller samples and shifts on exactly the edge SCK changes.
//   stall=1 freezes SCK at its current level and restarts the half-period.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   run         enable toggling; 0 forces SCK low and clears the phase
//   stall       hold SCK (used only while SCK is low)
//   sck         bus clock level
//   rise, fall  edge strobes (see above)
module qspi_sck_divider
   import qspi_host_interface_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic stall,
   output logic sck,
   output logic rise,
   output logic fall
);

   localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

   logic [7:0] cnt_reg;
   logic       sck_reg;
   logic       tick;

   assign tick = run && !stall && (cnt_reg == TERM);
   assign rise = tick && !sck_reg;
   assign fall = tick && sck_reg;
   assign sck  = sck_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= 8'd0;
         sck_reg <= 1'b0;
      end else if (!run) begin
         cnt_reg <= 8'd0;
         sck_reg <= 1'b0;
      end else if (stall) begin
         cnt_reg <= 8'd0;
      end else if (tick) begin
         cnt_reg <= 8'd0;
         sck_reg <= ~sck_reg;
      end else begin
         cnt_reg <= cnt_reg + 8'd1;
      end
   end

endmodule

// File: rtl/qspi_host_interface.sv
// qspi_host_interface
//   Quad-SPI host, SPI mode 0 on four data lines. A transaction is
//   CS setup, a 16-bit instruction (4 nibbles), an optional turnaround
//   with DQ released (reads), len data bytes (high nibble first), CS hold,
//   then a CS-high idle gap before done.
//   Write bytes go through a one-byte buffer so the next byte is normally
//   fetched well before it is needed; if the buffer is empty when a new
//   byte must be driven, SCK is held low until it arrives.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, insn, rd_mode, len  transaction request (captured on start)
//   wr_ready/wr_valid/wr_data  write byte handshake
//   rd_valid/rd_data           read byte strobe and value
//   busy, done                 status
//   qspi_sck, qspi_cs_n        bus clock and chip select
//   qspi_dq_out/_oe/_in        data lines (driven value, enable, sampled)
module qspi_host_interface
   import qspi_host_interface_pkg::*;
#(
   parameter int unsigned CLK_DIV           = DEFAULT_CLK_DIV,
   parameter int unsigned TURNAROUND_CYCLES = DEFAULT_TURNAROUND
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] insn,
   input  logic        rd_mode,
   input  logic [15:0] len,
   output logic        wr_ready,
   input  logic        wr_valid,
   input  logic [7:0]  wr_data,
   output logic        rd_valid,
   output logic [7:0]  rd_data,
   output logic        busy,
   output logic        done,
   output logic        qspi_sck,
   output logic        qspi_cs_n,
   output logic [3:0]  qspi_dq_out,
   output logic        qspi_dq_oe,
   input  logic [3:0]  qspi_dq_in
);

   localparam logic [7:0] TA_LAST   = (TURNAROUND_CYCLES == 0) ? 8'd0 : 8'(TURNAROUND_CYCLES - 1);
   localparam logic [8:0] HOLD_LAST = 9'(CLK_DIV - 1);
   localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

   qspi_state_t state_reg, state_next, after_insn;

   logic [15:0] insn_reg, len_reg;
   logic        rd_mode_reg;
   logic [1:0]  nib_reg;          // instruction nibble currently on DQ
   logic [7:0]  ta_cnt_reg;       // turnaround SCK cycles completed
   logic        half_reg;         // 1 = next data nibble is the low one
   logic [15:0] byte_cnt_reg;     // data bytes fully clocked on the bus
   logic [15:0] fetch_cnt_reg;    // write bytes accepted from the user
   logic [7:0]  wbuf_reg;
   logic        wbuf_full_reg;
   logic [3:0]  low_reg;          // low nibble of the byte being sent
   logic        need_byte_reg;    // stalled waiting for a write byte
   logic [3:0]  rd_hi_reg;
   logic [7:0]  rd_data_reg;
   logic        rd_valid_reg;
   logic [8:0]  wait_reg;
   logic        done_reg;
   logic [3:0]  dq_reg;

   logic run, sck_rise, sck_fall, accept, need_new, wr_xfer;

   qspi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .stall (need_byte_reg),
      .sck   (qspi_sck),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      run        = 1'b0;
      qspi_cs_n  = 1'b1;
      qspi_dq_oe = 1'b0;
      wr_ready   = 1'b0;
      need_new   = 1'b0;
      accept     = 1'b0;

      if (len_reg == 16'd0)                           after_insn = ST_CS_HOLD;
      else if (rd_mode_reg && TURNAROUND_CYCLES != 0) after_insn = ST_TURNAROUND;
      else                                            after_insn = ST_DATA;

      case (state_reg)
         ST_IDLE: begin
            // done_reg high means this is the done cycle; start is ignored
            if (start && !done_reg) begin
               accept     = 1'b1;
               state_next = ST_CS_SETUP;
            end
         end
         ST_CS_SETUP: begin
            run        = 1'b1;
            qspi_cs_n  = 1'b0;
            qspi_dq_oe = 1'b1;
            if (sck_rise) state_next = ST_INSN;
         end
         ST_INSN: begin
            run        = 1'b1;
            qspi_cs_n  = 1'b0;
            qspi_dq_oe = 1'b1;
            if (sck_fall && nib_reg == 2'd3) begin
               state_next = after_insn;
               need_new   = !rd_mode_reg && (len_reg != 16'd0);
            end
         end
         ST_TURNAROUND: begin
            run       = 1'b1;
            qspi_cs_n = 1'b0;
            if (sck_fall && ta_cnt_reg == TA_LAST) state_next = ST_DATA;
         end
         ST_DATA: begin
            run        = 1'b1;
            qspi_cs_n  = 1'b0;
            qspi_dq_oe = !rd_mode_reg;
            if (sck_fall && !half_reg) begin
               if (byte_cnt_reg == len_reg) state_next = ST_CS_HOLD;
               else                         need_new   = !rd_mode_reg;
            end
         end
         ST_CS_HOLD: begin
            qspi_cs_n  = 1'b0;
            qspi_dq_oe = !rd_mode_reg || (len_reg == 16'd0);
            if (wait_reg == HOLD_LAST) state_next = ST_CS_IDLE;
         end
         ST_CS_IDLE: begin
            if (wait_reg == GAP_LAST) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      if (state_reg == ST_CS_SETUP || state_reg == ST_INSN || state_reg == ST_DATA)
         wr_ready = !rd_mode_reg && !wbuf_full_reg && (fetch_cnt_reg != len_reg);
   end

   assign wr_xfer = wr_ready && wr_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         insn_reg      <= 16'd0;
         len_reg       <= 16'd0;
         rd_mode_reg   <= 1'b0;
         nib_reg       <= 2'd0;
         ta_cnt_reg    <= 8'd0;
         half_reg      <= 1'b0;
         byte_cnt_reg  <= 16'd0;
         fetch_cnt_reg <= 16'd0;
         wbuf_reg      <= 8'd0;
         wbuf_full_reg <= 1'b0;
         low_reg       <= 4'd0;
         need_byte_reg <= 1'b0;
         rd_hi_reg     <= 4'd0;
         rd_data_reg   <= 8'd0;
         rd_valid_reg  <= 1'b0;
         wait_reg      <= 9'd0;
         done_reg      <= 1'b0;
         dq_reg        <= 4'd0;
      end else begin
         rd_valid_reg <= 1'b0;
         done_reg     <= (state_reg == ST_CS_IDLE) && (state_next == ST_IDLE);

         if (state_next != state_reg) wait_reg <= 9'd0;
         else if (state_reg == ST_CS_HOLD || state_reg == ST_CS_IDLE) wait_reg <= wait_reg + 9'd1;

         if (accept) begin
            insn_reg      <= insn;
            len_reg       <= len;
            rd_mode_reg   <= rd_mode;
            dq_reg        <= insn[15:12];
            nib_reg       <= 2'd0;
            ta_cnt_reg    <= 8'd0;
            half_reg      <= 1'b0;
            byte_cnt_reg  <= 16'd0;
            fetch_cnt_reg <= 16'd0;
            wbuf_full_reg <= 1'b0;
            need_byte_reg <= 1'b0;
         end

         if (wr_xfer) begin
            wbuf_reg      <= wr_data;
            wbuf_full_reg <= 1'b1;
            fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
         end

         case (state_reg)
            ST_INSN: begin
               if (sck_fall && nib_reg != 2'd3) begin
                  nib_reg <= nib_reg + 2'd1;
                  dq_reg  <= insn_nibble(insn_reg, nib_reg + 2'd1);
               end
            end
            ST_TURNAROUND: begin
               if (sck_fall) ta_cnt_reg <= ta_cnt_reg + 8'd1;
            end
            ST_DATA: begin
               if (sck_rise) begin
                  half_reg <= ~half_reg;
                  if (half_reg) byte_cnt_reg <= byte_cnt_reg + 16'd1;
                  if (rd_mode_reg) begin
                     if (!half_reg) begin
                        rd_hi_reg <= qspi_dq_in;
                     end else begin
                        rd_data_reg  <= {rd_hi_reg, qspi_dq_in};
                        rd_valid_reg <= 1'b1;
                     end
                  end
               end
               if (sck_fall && half_reg && !rd_mode_reg) dq_reg <= low_reg;
            end
            default: ;
         endcase

         // A new write byte goes on DQ right away if buffered; otherwise
         // SCK stalls low until the buffer fills.
         if (need_new) begin
            if (wbuf_full_reg) begin
               dq_reg        <= wbuf_reg[7:4];
               low_reg       <= wbuf_reg[3:0];
               wbuf_full_reg <= 1'b0;
            end else begin
               need_byte_reg <= 1'b1;
            end
         end else if (need_byte_reg && wbuf_full_reg) begin
            dq_reg        <= wbuf_reg[7:4];
            low_reg       <= wbuf_reg[3:0];
            wbuf_full_reg <= 1'b0;
            need_byte_reg <= 1'b0;
         end
      end
   end

   assign busy        = (state_reg != ST_IDLE);
   assign done        = done_reg;
   assign rd_valid    = rd_valid_reg;
   assign rd_data     = rd_data_reg;
   assign qspi_dq_out = dq_reg;

endmodule

// File: tb/tb_qspi_host_interface.sv
module tb_qspi_host_interface;

   localparam int CLK_DIV = 2;
   localparam int TA      = 2;
   localparam int BUDGET  = 3000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] insn = 16'h0;
   logic        rd_mode = 1'b0;
   logic [15:0] len = 16'h0;
   logic        wr_ready;
   logic        wr_valid = 1'b0;
   logic [7:0]  wr_data = 8'h0;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        busy, done;
   logic        qspi_sck, qspi_cs_n, qspi_dq_oe;
   logic [3:0]  qspi_dq_out;
   logic [3:0]  qspi_dq_in = 4'h0;

   qspi_host_interface #(.CLK_DIV(CLK_DIV), .TURNAROUND_CYCLES(TA)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .insn(insn), .rd_mode(rd_mode),
      .len(len), .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
      .qspi_sck(qspi_sck), .qspi_cs_n(qspi_cs_n), .qspi_dq_out(qspi_dq_out),
      .qspi_dq_oe(qspi_dq_oe), .qspi_dq_in(qspi_dq_in)
   );

   always #5 clk = ~clk;

   int check_cnt = 0;
   int err_cnt   = 0;

   task automatic check(input string name, input int act, input int exp);
      check_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Bus model: record {oe, dq} at every SCK rise; a device drives read
   // nibbles after each SCK fall.
   int         rise_cnt = 0;
   int         rise_base = 0;
   logic [4:0] nib_q[$];
   logic [7:0] rd_mem [4];

   always @(posedge qspi_sck) begin
      rise_cnt = rise_cnt + 1;
      nib_q.push_back({qspi_dq_oe, qspi_dq_out});
   end

   always @(negedge qspi_sck) begin
      int r;
      r = rise_cnt - rise_base - 4 - TA;
      if (r >= 0 && r < 8) qspi_dq_in = r[0] ? rd_mem[r[2:1]][3:0] : rd_mem[r[2:1]][7:4];
   end

   function automatic logic [4:0] nib_at(input int idx);
      if (idx < nib_q.size()) return nib_q[idx];
      return 5'h0;
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] data, input int k);
      logic [31:0] t;
      t = data << (8 * k);
      return t[31:24];
   endfunction

   typedef struct {
      logic [15:0] insn;
      logic        rd;
      logic [15:0] len;
      logic [31:0] data;       // first byte in the MSBs
      int          stall_idx;  // write byte preceded by a 20-clk gap, -1 none
      int          rises;      // expected SCK rising edges
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input vec_t v, input int id);
      int nb, cycles, dn, wrrdy, low_run, max_low, widx, hold, oe_low, n;
      logic pend;
      logic [15:0] got_insn;
      logic [7:0] rdq[$];
      logic [7:0] b;
      logic [4:0] hi, lo;
      rise_base = rise_cnt;
      nb = nib_q.size();
      for (int k = 0; k < 4; k++) rd_mem[k] = byte_of(v.data, k);
      dn = 0; wrrdy = 0; low_run = 0; max_low = 0; widx = 0; hold = 0; pend = 1'b0;
      @(negedge clk);
      insn = v.insn; rd_mode = v.rd; len = v.len; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      insn = ~v.insn; len = 16'hFFFF; rd_mode = ~v.rd;
      check("busy_after_start", int'(busy), 1);
      cycles = 0;
      while (1) begin
         if (pend) begin widx++; pend = 1'b0; end
         if (!v.rd && widx < int'(v.len)) begin
            if (widx == v.stall_idx && hold < 20) begin
               wr_valid = 1'b0;
               if (wr_ready) hold++;
            end else begin
               wr_valid = 1'b1;
               wr_data  = byte_of(v.data, widx);
            end
         end else begin
            wr_valid = 1'b0;
         end
         if (wr_valid && wr_ready) pend = 1'b1;
         if (wr_ready) wrrdy++;
         if (rd_valid) rdq.push_back(rd_data);
         if (done) dn++;
         if (!qspi_cs_n && !qspi_sck) low_run++; else low_run = 0;
         if (low_run > max_low) max_low = low_run;
         if (dn > 0 || cycles >= BUDGET) break;
         cycles++;
         @(negedge clk);
      end
      wr_valid = 1'b0;
      check("done_timeout", int'(cycles < BUDGET), 1);
      repeat (6) begin
         @(negedge clk);
         if (done) dn++;
         if (rd_valid) rdq.push_back(rd_data);
      end
      check("done_pulses", dn, 1);
      check("sck_rises", rise_cnt - rise_base, v.rises);
      n = nib_q.size() - nb;
      got_insn = {nib_at(nb)[3:0], nib_at(nb+1)[3:0], nib_at(nb+2)[3:0], nib_at(nb+3)[3:0]};
      check("insn_decoded", int'(got_insn), int'(v.insn));
      check("insn_oe", int'(nib_at(nb)[4] & nib_at(nb+1)[4] & nib_at(nb+2)[4] & nib_at(nb+3)[4]), 1);
      oe_low = 0;
      for (int k = 4; k < n; k++) if (!nib_at(nb + k)[4]) oe_low++;
      if (!v.rd) begin
         check("write_oe_low_rises", oe_low, 0);
         for (int k = 0; k < int'(v.len); k++) begin
            hi = nib_at(nb + 4 + 2*k);
            lo = nib_at(nb + 5 + 2*k);
            b = {hi[3:0], lo[3:0]};
            check($sformatf("wr_byte%0d", k), int'(b), int'(byte_of(v.data, k)));
         end
         if (v.len == 16'd0) check("len0_no_wr_ready", wrrdy, 0);
      end else begin
         check("read_oe_low_rises", oe_low, v.rises - 4);
         check("rd_valid_count", rdq.size(), int'(v.len));
         for (int k = 0; k < int'(v.len) && k < rdq.size(); k++)
            check($sformatf("rd_byte%0d", k), int'(rdq[k]), int'(byte_of(v.data, k)));
      end
      if (v.stall_idx >= 0) check("stall_sck_low", int'(max_low >= 12), 1);
      else                  check("no_stall_sck_low", int'(max_low <= 2*CLK_DIV), 1);
      $display("TXN %0d insn=%h rd=%0d len=%0d rises=%0d insn_seen=%h rd_bytes=%0d max_low=%0d",
               id, v.insn, v.rd, v.len, rise_cnt - rise_base, got_insn, rdq.size(), max_low);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, cnt_dn, cnt_rv, cnt_cs, nb;
      logic [15:0] got;

      vecs[0] = '{insn:16'h0003, rd:1'b0, len:16'd4, data:32'hC0A80102, stall_idx:-1, rises:12};
      vecs[1] = '{insn:16'h0000, rd:1'b1, len:16'd4, data:32'h364B8093, stall_idx:-1, rises:14};
      vecs[2] = '{insn:16'h0002, rd:1'b0, len:16'd4, data:32'h11223344, stall_idx:1,  rises:12};
      vecs[3] = '{insn:16'h1234, rd:1'b0, len:16'd0, data:32'h0,        stall_idx:-1, rises:4};
      vecs[4] = '{insn:16'h6B5A, rd:1'b1, len:16'd2, data:32'hA53C0000, stall_idx:-1, rises:10};
      vecs[5] = '{insn:16'h9F00, rd:1'b1, len:16'd0, data:32'h0,        stall_idx:-1, rises:4};

      // Reset state
      #12;
      check("reset_outputs",
            int'({qspi_cs_n, qspi_sck, qspi_dq_oe, qspi_dq_out, wr_ready, rd_valid, rd_data, busy, done}),
            int'({1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}));
      $display("TXN reset cs_n=%0d sck=%0d oe=%0d busy=%0d", qspi_cs_n, qspi_sck, qspi_dq_oe, busy);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Reset during the first data byte of a read
      rise_base = rise_cnt;
      for (int k = 0; k < 4; k++) rd_mem[k] = byte_of(32'h364B8093, k);
      @(negedge clk);
      insn = 16'h0000; rd_mode = 1'b1; len = 16'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (rise_cnt - rise_base < 7 && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_byte1_timeout", int'(cyc < BUDGET), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_cs_n", int'(qspi_cs_n), 1);
      check("rst_mid_oe", int'(qspi_dq_oe), 0);
      check("rst_mid_sck_busy", int'({qspi_sck, busy}), 0);
      cnt_dn = 0; cnt_rv = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) cnt_dn++;
         if (rd_valid) cnt_rv++;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (done) cnt_dn++;
         if (rd_valid) cnt_rv++;
      end
      check("rst_mid_no_rd_valid", cnt_rv, 0);
      check("rst_mid_no_done", cnt_dn, 0);
      $display("TXN reset_mid_read rises=%0d rd_valid=%0d done=%0d", rise_cnt - rise_base, cnt_rv, cnt_dn);
      run_vec(vecs[0], 10);

      // start while busy and start coincident with done are ignored
      rise_base = rise_cnt;
      nb = nib_q.size();
      @(negedge clk);
      insn = 16'h1234; rd_mode = 1'b0; len = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      insn = 16'hFFFF; rd_mode = 1'b1; len = 16'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check("ignore_done_timeout", int'(cyc < BUDGET), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_on_done_busy", int'(busy), 0);
      cnt_cs = 0; cnt_dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (!qspi_cs_n) cnt_cs++;
         if (done) cnt_dn++;
      end
      check("ignored_no_cs", cnt_cs, 0);
      check("ignored_no_done", cnt_dn, 0);
      check("ignored_rises", rise_cnt - rise_base, 4);
      got = {nib_at(nb)[3:0], nib_at(nb+1)[3:0], nib_at(nb+2)[3:0], nib_at(nb+3)[3:0]};
      check("ignored_insn", int'(got), 16'h1234);
      $display("TXN start_ignore rises=%0d insn_seen=%h cs_after_done=%0d", rise_cnt - rise_base, got, cnt_cs);

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule
